// File: rtl/i2c_eeprom_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_slave_if
//  Description : Bus bundle between an I2C master model and the EEPROM slave:
//                oversampled SCL / resolved SDA in, SDA pull-down enable out,
//                write protect, plus busy and address-pointer status.
//  Revision    : 1.0  initial release
// ============================================================================
interface i2c_eeprom_slave_if #(
   parameter int MEM_AW = 8
);
   logic              scl;
   logic              sda_in;
   logic              sda_oe;
   logic              wp;
   logic              busy;
   logic [MEM_AW-1:0] addr_ptr;

   modport slave (
      input  scl,
      input  sda_in,
      input  wp,
      output sda_oe,
      output busy,
      output addr_ptr
   );

   modport master (
      output scl,
      output sda_in,
      output wp,
      input  sda_oe,
      input  busy,
      input  addr_ptr
   );
endinterface
`default_nettype wire

// File: rtl/i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_eeprom_slave
//  Description : 24LC-style I2C EEPROM slave. Oversamples SCL/SDA on clk,
//                decodes START/STOP/repeated START, supports byte/page write,
//                current-address, random and sequential read, and emulates
//                the internal write cycle with a busy timer.
//  Revision    : 1.0  initial release
// ============================================================================
module i2c_eeprom_slave #(
   parameter logic [6:0] DEV_ADDR    = 7'b1010000,
   parameter int         MEM_AW      = 8,
   parameter int         PAGE_SIZE   = 32,
   parameter int         T_WR_CYCLES = 500000
) (
   input  wire logic         clk,
   input  wire logic         reset,
   i2c_eeprom_slave_if.slave bus
);
   localparam int                c_TW        = $clog2(T_WR_CYCLES + 1);
   localparam logic [MEM_AW-1:0] c_PAGE_MASK = MEM_AW'(PAGE_SIZE - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_DEV, S_ACK_DEV, S_AHI, S_ACK_AHI, S_ALO, S_ACK_ALO,
      S_WDATA, S_ACK_W, S_RDATA, S_MACK
   } state_t;

   state_t            state_q, state_d;
   logic              scl_s1_q, scl_s2_q, scl_prev_q;
   logic              sda_s1_q, sda_s2_q, sda_prev_q;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic              rw_q, rw_d;
   logic [MEM_AW-1:0] addr_ptr_q, addr_ptr_d;
   logic              sda_oe_q, sda_oe_d;
   logic              wr_pending_q, wr_pending_d;
   logic              busy_q, busy_d;
   logic [c_TW-1:0]   timer_q, timer_d;
   logic              w_mem_we;

   // Array powers up erased (all 0xFF); reset deliberately leaves it alone.
   logic [7:0] mem_q [2**MEM_AW] = '{default: 8'hFF};

   logic              w_scl_rise, w_scl_fall, w_start, w_stop, w_byte_done;
   logic [7:0]        w_rd_byte;
   logic [MEM_AW-1:0] w_page_inc, w_load_addr;

   assign w_scl_rise  = scl_s2_q & ~scl_prev_q;
   assign w_scl_fall  = ~scl_s2_q & scl_prev_q;
   assign w_start     = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
   assign w_stop      = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
   assign w_byte_done = w_scl_fall & (bit_cnt_q == 4'd8);
   assign w_rd_byte   = mem_q[addr_ptr_q];
   // Page write: upper address bits hold, bits inside the page wrap.
   assign w_page_inc  = (addr_ptr_q & ~c_PAGE_MASK) | ((addr_ptr_q + 1'b1) & c_PAGE_MASK);

   generate
      if (MEM_AW > 8) begin : g_wide_addr
         logic [MEM_AW-9:0] addr_hi_q;
         // Keep only the implemented part of the address high byte.
         always_ff @(posedge clk) begin
            if (reset)                                addr_hi_q <= '0;
            else if (state_q == S_AHI && w_byte_done) addr_hi_q <= shift_q[MEM_AW-9:0];
         end
         assign w_load_addr = {addr_hi_q, shift_q};
      end else begin : g_narrow_addr
         assign w_load_addr = shift_q[MEM_AW-1:0];
      end
   endgenerate

   // Bring SCL/SDA into the clk domain and keep the previous sample for edge detect.
   always_ff @(posedge clk) begin
      if (reset) begin
         scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_prev_q <= 1'b1;
         sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_prev_q <= 1'b1;
      end else begin
         scl_s1_q <= bus.scl;    scl_s2_q <= scl_s1_q; scl_prev_q <= scl_s2_q;
         sda_s1_q <= bus.sda_in; sda_s2_q <= sda_s1_q; sda_prev_q <= sda_s2_q;
      end
   end

   // Protocol state and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         rw_q         <= 1'b0;
         addr_ptr_q   <= '0;
         sda_oe_q     <= 1'b0;
         wr_pending_q <= 1'b0;
         busy_q       <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         rw_q         <= rw_d;
         addr_ptr_q   <= addr_ptr_d;
         sda_oe_q     <= sda_oe_d;
         wr_pending_q <= wr_pending_d;
         busy_q       <= busy_d;
         timer_q      <= timer_d;
      end
   end

   // Array write port, committed when a write-data byte completes.
   always_ff @(posedge clk) begin
      if (w_mem_we) mem_q[addr_ptr_q] <= shift_q;
   end

   // Next-state logic: START/STOP override everything, otherwise bit-level protocol.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rw_d         = rw_q;
      addr_ptr_d   = addr_ptr_q;
      sda_oe_d     = sda_oe_q;
      wr_pending_d = wr_pending_q;
      busy_d       = busy_q;
      timer_d      = timer_q;
      w_mem_we     = 1'b0;

      if (busy_q) begin
         timer_d = timer_q - 1'b1;
         if (timer_q <= c_TW'(1)) busy_d = 1'b0;
      end

      if (w_stop) begin
         state_d   = S_IDLE;
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
         if (wr_pending_q) begin
            wr_pending_d = 1'b0;
            busy_d       = 1'b1;
            timer_d      = c_TW'(T_WR_CYCLES);
         end
      end else if (w_start) begin
         state_d   = S_DEV;
         sda_oe_d  = 1'b0;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            S_DEV, S_AHI, S_ALO, S_WDATA: begin
               if (w_scl_rise && bit_cnt_q != 4'd8) begin
                  shift_d   = {shift_q[6:0], sda_s2_q};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (w_byte_done) begin
                  bit_cnt_d = '0;
                  sda_oe_d  = 1'b1;
                  case (state_q)
                     S_DEV: begin
                        if (shift_q[7:1] == DEV_ADDR && !busy_q) begin
                           rw_d    = shift_q[0];
                           state_d = S_ACK_DEV;
                        end else begin
                           sda_oe_d = 1'b0;
                           state_d  = S_IDLE;
                        end
                     end
                     S_AHI: state_d = S_ACK_AHI;
                     S_ALO: begin
                        addr_ptr_d = w_load_addr;
                        state_d    = S_ACK_ALO;
                     end
                     default: begin
                        // Protected writes are still acknowledged, just not stored.
                        if (!bus.wp) begin
                           w_mem_we     = 1'b1;
                           wr_pending_d = 1'b1;
                        end
                        addr_ptr_d = w_page_inc;
                        state_d    = S_ACK_W;
                     end
                  endcase
               end
            end
            S_ACK_DEV, S_ACK_AHI, S_ACK_ALO, S_ACK_W: begin
               if (w_scl_fall) begin
                  sda_oe_d  = 1'b0;
                  bit_cnt_d = '0;
                  case (state_q)
                     S_ACK_DEV: begin
                        if (rw_q) begin
                           shift_d  = w_rd_byte;
                           sda_oe_d = ~w_rd_byte[7];
                           state_d  = S_RDATA;
                        end else begin
                           state_d  = S_AHI;
                        end
                     end
                     S_ACK_AHI: state_d = S_ALO;
                     default:   state_d = S_WDATA;
                  endcase
               end
            end
            S_RDATA: begin
               if (w_scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (w_scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d   = 1'b0;
                     addr_ptr_d = addr_ptr_q + 1'b1;
                     state_d    = S_MACK;
                  end else if (bit_cnt_q != 4'd0) begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end
            S_MACK: begin
               if (w_scl_rise && sda_s2_q) begin
                  state_d = S_IDLE;
               end else if (w_scl_fall) begin
                  bit_cnt_d = '0;
                  shift_d   = w_rd_byte;
                  sda_oe_d  = ~w_rd_byte[7];
                  state_d   = S_RDATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.sda_oe   = sda_oe_q;
   assign bus.busy     = busy_q;
   assign bus.addr_ptr = addr_ptr_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_eeprom_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_eeprom_slave
//  Description : Directed bench for i2c_eeprom_slave; bit-banged I2C master
//                with hand-computed expected data per scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_eeprom_slave;
   localparam int Q = 2;   // clk cycles per quarter SCL period

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       sda_m   = 1'b1;
   logic       oe_seen = 1'b0;
   int         checks  = 0;
   int         errors  = 0;
   int         nack_cnt;
   logic [7:0] rd_buf [0:7];

   always #5 clk = ~clk;

   i2c_eeprom_slave_if #(.MEM_AW(8)) bus_if ();
   assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

   i2c_eeprom_slave #(
      .DEV_ADDR(7'b1010000), .MEM_AW(8), .PAGE_SIZE(32), .T_WR_CYCLES(100)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus_if.slave)
   );

   // Sticky record of any slave pull-down, cleared by the scenarios that need it.
   always @(negedge clk) if (bus_if.sda_oe === 1'b1) oe_seen = 1'b1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; tick(Q);
      bus_if.scl = 1'b1; tick(Q);
      sda_m = 1'b0; tick(Q);
      bus_if.scl = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; tick(Q);
      bus_if.scl = 1'b1; tick(Q);
      sda_m = 1'b1; tick(Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b; tick(Q);
      bus_if.scl = 1'b1; tick(2 * Q);
      bus_if.scl = 1'b0; tick(Q);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1; tick(Q);
      bus_if.scl = 1'b1; tick(Q);
      b = bus_if.sda_in; tick(Q);
      bus_if.scl = 1'b0; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic nk);
      for (int i = 7; i >= 0; i--) write_bit(d[i]);
      read_bit(nk);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nk);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         d[i] = b;
      end
      write_bit(nk);
   endtask

   task automatic rand_read(input logic [7:0] addr, input int n);
      logic nk;
      i2c_start();
      write_byte(8'hA0, nk); nack_cnt += int'(nk);
      write_byte(8'h00, nk); nack_cnt += int'(nk);
      write_byte(addr,  nk); nack_cnt += int'(nk);
      i2c_start();
      write_byte(8'hA1, nk); nack_cnt += int'(nk);
      for (int i = 0; i < n; i++) read_byte(rd_buf[i], (i == n - 1));
      i2c_stop();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      tick(10);
      while (bus_if.busy === 1'b1 && n < 300) begin
         tick(1);
         n++;
      end
      checks++;
      if (bus_if.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s busy_timeout: busy=%b required 0", tag, bus_if.busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; tick(5);
      reset = 1'b0; tick(2);
      checks++; if (bus_if.sda_oe !== 1'b0) begin errors++; $display("FAIL reset_sda_oe: got %b required 0", bus_if.sda_oe); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus_if.busy); end
      checks++; if (bus_if.addr_ptr !== 8'h00) begin errors++; $display("FAIL reset_addr_ptr: got %h required 00", bus_if.addr_ptr); end
   endtask

   task automatic test_write_read();
      logic [7:0] seq [7] = '{8'hA0, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
      logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      logic       nk;
      int         n;
      i2c_start();
      for (int i = 0; i < 7; i++) begin
         write_byte(seq[i], nk);
         checks++;
         if (nk !== 1'b0) begin errors++; $display("FAIL wr_ack[%0d]: got %b required 0", i, nk); end
      end
      i2c_stop();
      n = 0;
      while (bus_if.busy !== 1'b1 && n < 20) begin tick(1); n++; end
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL wr_busy_rise: got %b required 1", bus_if.busy); end
      n = 0;
      while (bus_if.busy === 1'b1 && n < 300) begin tick(1); n++; end
      checks++; if (n != 100) begin errors++; $display("FAIL wr_busy_len: got %0d required 100", n); end
      checks++; if (bus_if.addr_ptr !== 8'h04) begin errors++; $display("FAIL wr_addr_ptr: got %h required 04", bus_if.addr_ptr); end
      nack_cnt = 0;
      rand_read(8'h00, 4);
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL rd_acks: got %0d nacks required 0", nack_cnt); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_buf[i] !== exp[i]) begin errors++; $display("FAIL rd_data[%0d]: got %h required %h", i, rd_buf[i], exp[i]); end
      end
      checks++; if (bus_if.addr_ptr !== 8'h04) begin errors++; $display("FAIL rd_addr_ptr: got %h required 04", bus_if.addr_ptr); end
      tick(20);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rd_no_busy: got %b required 0", bus_if.busy); end
   endtask

   task automatic test_busy_nack();
      logic nk;
      nack_cnt = 0;
      i2c_start();
      write_byte(8'hA0, nk); nack_cnt += int'(nk);
      write_byte(8'h00, nk); nack_cnt += int'(nk);
      write_byte(8'h40, nk); nack_cnt += int'(nk);
      write_byte(8'h5A, nk); nack_cnt += int'(nk);
      i2c_stop();
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL bn_write_acks: got %0d nacks required 0", nack_cnt); end
      oe_seen = 1'b0;
      i2c_start();
      checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL bn_busy_during: got %b required 1", bus_if.busy); end
      write_byte(8'hA0, nk);
      checks++; if (nk !== 1'b1) begin errors++; $display("FAIL bn_nack: got %b required 1", nk); end
      checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL bn_sda_oe: got %b required 0", oe_seen); end
      i2c_stop();
      wait_idle("bn");
      i2c_start();
      write_byte(8'hA0, nk);
      checks++; if (nk !== 1'b0) begin errors++; $display("FAIL bn_ack_after: got %b required 0", nk); end
      i2c_stop();
      tick(10);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL bn_no_write: got %b required 0", bus_if.busy); end
   endtask

   task automatic test_page_wrap();
      logic [7:0] seq [6] = '{8'hA0, 8'h00, 8'h1E, 8'h11, 8'h22, 8'h33};
      logic       nk;
      nack_cnt = 0;
      i2c_start();
      for (int i = 0; i < 6; i++) begin
         write_byte(seq[i], nk);
         nack_cnt += int'(nk);
      end
      i2c_stop();
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL pw_acks: got %0d nacks required 0", nack_cnt); end
      checks++; if (bus_if.addr_ptr !== 8'h01) begin errors++; $display("FAIL pw_addr_ptr: got %h required 01", bus_if.addr_ptr); end
      wait_idle("pw");
      rand_read(8'h1E, 2);
      checks++; if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL pw_mem1E: got %h required 11", rd_buf[0]); end
      checks++; if (rd_buf[1] !== 8'h22) begin errors++; $display("FAIL pw_mem1F: got %h required 22", rd_buf[1]); end
      rand_read(8'h00, 1);
      checks++; if (rd_buf[0] !== 8'h33) begin errors++; $display("FAIL pw_mem00: got %h required 33", rd_buf[0]); end
      rand_read(8'h20, 1);
      checks++; if (rd_buf[0] !== 8'hFF) begin errors++; $display("FAIL pw_mem20: got %h required FF", rd_buf[0]); end
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL pw_read_acks: got %0d nacks required 0", nack_cnt); end
   endtask

   task automatic test_read_wrap();
      logic nk;
      nack_cnt = 0;
      i2c_start();
      write_byte(8'hA0, nk); nack_cnt += int'(nk);
      write_byte(8'h00, nk); nack_cnt += int'(nk);
      write_byte(8'hFF, nk); nack_cnt += int'(nk);
      i2c_stop();
      tick(10);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rw_dummy_busy: got %b required 0", bus_if.busy); end
      checks++; if (bus_if.addr_ptr !== 8'hFF) begin errors++; $display("FAIL rw_ptr_set: got %h required FF", bus_if.addr_ptr); end
      i2c_start();
      write_byte(8'hA1, nk); nack_cnt += int'(nk);
      read_byte(rd_buf[0], 1'b0);
      read_byte(rd_buf[1], 1'b1);
      i2c_stop();
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL rw_acks: got %0d nacks required 0", nack_cnt); end
      checks++; if (rd_buf[0] !== 8'hFF) begin errors++; $display("FAIL rw_memFF: got %h required FF", rd_buf[0]); end
      checks++; if (rd_buf[1] !== 8'h33) begin errors++; $display("FAIL rw_mem00: got %h required 33", rd_buf[1]); end
      checks++; if (bus_if.addr_ptr !== 8'h01) begin errors++; $display("FAIL rw_ptr_after: got %h required 01", bus_if.addr_ptr); end
   endtask

   task automatic test_write_protect();
      logic nk;
      nack_cnt = 0;
      bus_if.wp = 1'b1;
      i2c_start();
      write_byte(8'hA0, nk); nack_cnt += int'(nk);
      write_byte(8'h00, nk); nack_cnt += int'(nk);
      write_byte(8'h10, nk); nack_cnt += int'(nk);
      write_byte(8'h55, nk); nack_cnt += int'(nk);
      i2c_stop();
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL wp_acks: got %0d nacks required 0", nack_cnt); end
      tick(20);
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL wp_busy: got %b required 0", bus_if.busy); end
      checks++; if (bus_if.addr_ptr !== 8'h11) begin errors++; $display("FAIL wp_addr_ptr: got %h required 11", bus_if.addr_ptr); end
      bus_if.wp = 1'b0;
      rand_read(8'h10, 1);
      checks++; if (rd_buf[0] !== 8'hFF) begin errors++; $display("FAIL wp_mem10: got %h required FF", rd_buf[0]); end
   endtask

   task automatic test_wrong_addr();
      logic nk;
      oe_seen = 1'b0;
      i2c_start();
      write_byte(8'hA4, nk);
      write_byte(8'h00, nk);
      i2c_stop();
      checks++; if (nk !== 1'b1) begin errors++; $display("FAIL wa_nack: got %b required 1", nk); end
      checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL wa_sda_oe: got %b required 0", oe_seen); end
   endtask

   task automatic test_reset_mid_read();
      logic nk, b;
      nack_cnt = 0;
      i2c_start();
      write_byte(8'hA0, nk); nack_cnt += int'(nk);
      write_byte(8'h00, nk); nack_cnt += int'(nk);
      write_byte(8'h02, nk); nack_cnt += int'(nk);
      i2c_start();
      write_byte(8'hA1, nk); nack_cnt += int'(nk);
      for (int i = 0; i < 3; i++) read_bit(b);
      tick(2);
      // mem[0x02] = C3: fourth bit is 0, so the slave is pulling SDA now
      checks++; if (bus_if.sda_oe !== 1'b1) begin errors++; $display("FAIL rm_bit4_driven: got %b required 1", bus_if.sda_oe); end
      reset = 1'b1;
      tick(1);
      checks++; if (bus_if.sda_oe !== 1'b0) begin errors++; $display("FAIL rm_sda_release: got %b required 0", bus_if.sda_oe); end
      checks++; if (bus_if.addr_ptr !== 8'h00) begin errors++; $display("FAIL rm_addr_ptr: got %h required 00", bus_if.addr_ptr); end
      reset = 1'b0;
      oe_seen = 1'b0;
      for (int i = 0; i < 5; i++) read_bit(b);
      write_bit(1'b1);
      i2c_stop();
      checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rm_bus_ignored: got %b required 0", oe_seen); end
      rand_read(8'h02, 2);
      checks++; if (nack_cnt != 0) begin errors++; $display("FAIL rm_acks: got %0d nacks required 0", nack_cnt); end
      checks++; if (rd_buf[0] !== 8'hC3) begin errors++; $display("FAIL rm_mem02: got %h required C3", rd_buf[0]); end
      checks++; if (rd_buf[1] !== 8'hD4) begin errors++; $display("FAIL rm_mem03: got %h required D4", rd_buf[1]); end
   endtask

   initial begin
      bus_if.scl = 1'b1;
      bus_if.wp  = 1'b0;
      test_reset();
      test_write_read();
      test_busy_nack();
      test_page_wrap();
      test_read_wrap();
      test_write_protect();
      test_wrong_addr();
      test_reset_mid_read();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2c_eeprom_slave.md
Name: i2c_eeprom_slave

Overview:
Synthesizable I2C EEPROM slave, modelled on the 24LC-class serial EEPROM and sitting directly downstream of i2c_master on the shared SDA/SCL bus. It oversamples SCL/SDA on the system clock and decodes START, STOP and repeated START. It supports byte/page write, current-address read, random read and sequential read, and emulates the internal write cycle. It lets top_i2c be closed-loop tested on FPGA and in simulation without an external part.

Parameters:
DEV_ADDR, 7'b1010000, 7-bit device address (A2..A0 = 0).
MEM_AW, 8, implemented address bits; the upper address bits received are ignored.
PAGE_SIZE, 32, page-write wrap boundary in bytes (power of 2, ≤ 2^MEM_AW).
T_WR_CYCLES, 500000, internal write-cycle length in clk cycles (5 ms @ 100 MHz).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
scl  in  1  bus SCL (master-driven)
sda_in  in  1  resolved SDA line level
sda_oe  out  1  1 = pull SDA low; 0 = release
wp  in  1  write protect; 1 = array writes inhibited
busy  out  1  internal write cycle in progress
addr_ptr  out  MEM_AW  internal address pointer (debug/LED)

Behaviour:
- Sync: scl and sda_in each pass through a 2-FF synchronizer plus a previous-value register. Edges are detected on the synced values; detection latency is 3 clk.
- START = synced SDA falling while SCL high. STOP = SDA rising while SCL high. Both are valid in every state; START in any non-IDLE state is a repeated START.
- Data bits are sampled on SCL rising, MSB first. The slave changes sda_oe only on SCL falling.
- States: IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO, WDATA, ACK_W, RDATA, MACK.
- IDLE: on START, go to DEV with bit counter = 0.
- DEV: after 8 bits, compare bits[7:1] to DEV_ADDR.
  - Match and busy = 0: go to ACK_DEV.
  - Mismatch or busy = 1: NACK, sda_oe stays 0, go to IDLE and wait for the next START.
- ACK_DEV: sda_oe = 1 from the SCL fall after bit 8 until the next SCL fall. Then go to RDATA if R/W = 1, or AHI if R/W = 0.
- AHI/ALO: receive the address high and low bytes, ACK each. On ACK_ALO, load addr_ptr with the low MEM_AW bits of {hi, lo}, then go to WDATA.
- WDATA: after 8 bits, write mem[addr_ptr] unless wp = 1, and set wr_pending only if a write happened. ACK regardless of wp. Increment addr_ptr within the page: upper bits are held, low log2(PAGE_SIZE) bits wrap, so 0x1F+1 gives 0x00 for PAGE_SIZE = 32.
- RDATA: the shift register is loaded from mem[addr_ptr] on entry. Each SCL fall drives sda_oe = ~bit, MSB first. After the 8th bit, release SDA, increment addr_ptr with full-array wrap (0xFF→0x00), then go to MACK.
- MACK: sample SDA on SCL rise. ACK (0) → RDATA with the next byte. NACK (1) → IDLE with sda_oe = 0.
- STOP in any state: go to IDLE with sda_oe = 0. If wr_pending, clear it, set busy = 1 and load the timer with T_WR_CYCLES.
- The timer decrements every clk; busy drops the cycle the timer reaches 0.
- Repeated START after ALO (random read) goes to DEV and keeps addr_ptr. It does not start a write cycle.
- Current-address read uses the retained addr_ptr.
- Reset outputs: sda_oe = 0, busy = 0, addr_ptr = 0. State = IDLE, wr_pending = 0, timer = 0.
- Memory is initialised to 0xFF at configuration and is not cleared by reset.
- Reset mid-transfer releases SDA the next cycle. The bus is ignored until a fresh START.
- sda_oe is never asserted while SCL is high, except to hold an ACK or read bit that was set on the preceding SCL fall.

Test Plan:
- Write then read: with T_WR_CYCLES = 100, write 0xA0, 0x00, 0x00, A1, B2, C3, D4, then STOP. Expect 7 ACKs, busy high for 100 clk, addr_ptr = 0x04. Then random read of 4 bytes with master ACK×3 and NACK, STOP. Expect data A1 B2 C3 D4.
- Busy NACK: send 0xA0 during busy → SDA released at the 9th clock, state IDLE. Send again after busy falls → ACK.
- Page wrap: write 3 bytes 11 22 33 starting at 0x1E. Expect mem[0x1E] = 11, mem[0x1F] = 22, mem[0x00] = 33, and mem[0x20] unchanged at 0xFF.
- Read wrap and current-address read: set addr_ptr to 0xFF via a dummy write with no data followed by STOP. Expect no busy. Then 0xA1 sequential read of 2 bytes returns mem[0xFF] then mem[0x00].
- Write protect and wrong address: with wp = 1, write 0x55 at 0x10. Expect ACK, busy stays 0, and a read returns 0xFF. Address byte 0xA4 is NACKed with sda_oe never asserted.
- Reset mid-read: assert reset during bit 4 of RDATA → sda_oe = 0 the next cycle, state IDLE, addr_ptr = 0, memory contents intact on re-read.
